serializer: RTL and testbench

Parallel-to-serial converter: accepts one 16-bit word and shifts it out MSB-first on a single-bit line with a per-bit valid strobe. This is the transmit-side counterpart of the team's 16-bit deserializer: `ser_data_o`/`ser_data_val_o` connect directly to that block's `data_i`/`data_val_i`. A `data_mod_i` field allows variable-length words of 3..16 bits. `busy_o` gives upstream flow control.

---
 rtl/serializer.sv | 109 ++++++++++
 tb/tb_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, MSB first, variable length 3..DATA_W bits.
// Ports:
//   clk_i          - clock, rising edge
//   rst_n_i        - asynchronous active-low reset
//   data_i         - parallel word; bit DATA_W-1 is sent first
//   data_mod_i     - bits to send; 0 means DATA_W, 1 and 2 are dropped
//   data_val_i     - word valid, sampled when the block is ready
//   ser_data_o     - serial bit (0 whenever ser_data_val_o is 0)
//   ser_data_val_o - serial bit valid
//   busy_o         - transmission in progress
module serializer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   shift, shift_nxt;
   logic [MOD_W-1:0]    cnt, cnt_nxt;
   logic                ser_data_nxt;
   logic                ser_val_nxt;
   logic                busy_nxt;
   logic                legal;
   logic                accept;
   logic [MOD_W-1:0]    len_m1;

   // Length decode: 0 selects a full word, 1 and 2 are rejected.
   assign legal  = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
   assign len_m1 = (data_mod_i == '0) ? MOD_W'(DATA_W - 1) : data_mod_i - MOD_W'(1);

   // The edge that retires the last bit doubles as the idle edge, so a held
   // data_val_i streams words back-to-back with no gap.
   assign accept = data_val_i && legal && ((state == IDLE) || (cnt == '0));

   // Next-state and registered-output values.
   // The shift register holds the bits still to be sent; the bit on the line
   // is already in ser_data_o, so a load puts the MSB there directly.
   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift;
      cnt_nxt      = cnt;
      ser_data_nxt = 1'b0;
      ser_val_nxt  = 1'b0;
      busy_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt    = SEND;
               shift_nxt    = data_i << 1;
               cnt_nxt      = len_m1;
               ser_data_nxt = data_i[DATA_W-1];
               ser_val_nxt  = 1'b1;
               busy_nxt     = 1'b1;
            end
         end
         SEND: begin
            if (cnt != '0) begin
               shift_nxt    = shift << 1;
               cnt_nxt      = cnt - MOD_W'(1);
               ser_data_nxt = shift[DATA_W-1];
               ser_val_nxt  = 1'b1;
               busy_nxt     = 1'b1;
            end else if (accept) begin
               shift_nxt    = data_i << 1;
               cnt_nxt      = len_m1;
               ser_data_nxt = data_i[DATA_W-1];
               ser_val_nxt  = 1'b1;
               busy_nxt     = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= IDLE;
         shift          <= '0;
         cnt            <= '0;
         ser_data_o     <= 1'b0;
         ser_data_val_o <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         state          <= state_nxt;
         shift          <= shift_nxt;
         cnt            <= cnt_nxt;
         ser_data_o     <= ser_data_nxt;
         ser_data_val_o <= ser_val_nxt;
         busy_o         <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: self-checking bench for serializer.
// Table-driven vectors, hand-written multi-cycle sequences and randomized
// words checked against a queue-based model of the bit stream.
module tb_serializer;

   logic        clk_i;
   logic        rst_n_i;
   logic [15:0] data_i;
   logic [3:0]  data_mod_i;
   logic        data_val_i;
   logic        ser_data_o;
   logic        ser_data_val_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;
   bit exp_q[$];
   logic [15:0] rx;

   serializer dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .data_i         (data_i),
      .data_mod_i     (data_mod_i),
      .data_val_i     (data_val_i),
      .ser_data_o     (ser_data_o),
      .ser_data_val_o (ser_data_val_o),
      .busy_o         (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  m;
      int          len;
      logic [15:0] bits;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [15:0] d, input logic [3:0] m, input logic v);
      data_i     = d;
      data_mod_i = m;
      data_val_i = v;
   endtask

   // Reference: a legal word contributes its top len bits, MSB first.
   function automatic void model_push(input logic [15:0] d, input logic [3:0] m);
      int len;
      if (m == 4'd1 || m == 4'd2) return;
      len = (m == 4'd0) ? 16 : int'(m);
      for (int i = 0; i < len; i++) exp_q.push_back(d[15-i]);
   endfunction

   // One cycle of output checking against the expected-bit queue.
   task automatic check_cycle();
      bit b;
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
         b = exp_q.pop_front();
         check("val_active", ser_data_val_o, 1);
         check("busy_active", busy_o, 1);
         check("bit", ser_data_o, b);
         rx = {rx[14:0], ser_data_o};
      end else begin
         check("val_idle", ser_data_val_o, 0);
         check("busy_idle", busy_o, 0);
         check("bit_idle", ser_data_o, 0);
      end
   endtask

   task automatic send_word(input logic [15:0] d, input logic [3:0] m);
      int n;
      @(negedge clk_i);
      drive(d, m, 1'b1);
      model_push(d, m);
      n = exp_q.size();
      @(posedge clk_i);
      #1;
      data_val_i = 1'b0;
      data_i     = 16'($urandom);
      repeat (n + 2) check_cycle();
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 4'd0,  16, 16'hA5C3};
      vecs[1] = '{16'hE800, 4'd5,   5, 16'hE800};
      vecs[2] = '{16'h1234, 4'd1,   0, 16'h0000};
      vecs[3] = '{16'hABCD, 4'd2,   0, 16'h0000};
      vecs[4] = '{16'hFFFF, 4'd3,   3, 16'hE000};
      vecs[5] = '{16'h8001, 4'd15, 15, 16'h8000};
      vecs[6] = '{16'h7FFF, 4'd4,   4, 16'h7000};

      rst_n_i = 1'b0;
      drive(16'h0, 4'd0, 1'b0);
      rx = '0;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst_bit", ser_data_o, 0);
      check("rst_val", ser_data_val_o, 0);
      check("rst_busy", busy_o, 0);
      rst_n_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_i = 16'($urandom);
         check_cycle();
      end

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         rx = '0;
         @(negedge clk_i);
         drive(vecs[i].d, vecs[i].m, 1'b1);
         for (int k = 0; k < vecs[i].len; k++) exp_q.push_back(vecs[i].bits[15-k]);
         @(posedge clk_i);
         #1;
         data_val_i = 1'b0;
         repeat (vecs[i].len + 3) check_cycle();
         if (vecs[i].len == 16) check("rx_word", rx, vecs[i].bits);
      end

      // Pulse during transmission is ignored
      @(negedge clk_i);
      drive(16'hA5C3, 4'd0, 1'b1);
      model_push(16'hA5C3, 4'd0);
      @(posedge clk_i);
      #1;
      data_val_i = 1'b0;
      for (int k = 0; k < 19; k++) begin
         check_cycle();
         if (k == 5) drive(16'hFFFF, 4'd0, 1'b1);
         if (k == 6) data_val_i = 1'b0;
      end

      // Back-to-back words with data_val_i held
      rx = '0;
      @(negedge clk_i);
      drive(16'h8001, 4'd0, 1'b1);
      model_push(16'h8001, 4'd0);
      model_push(16'h00FF, 4'd0);
      @(posedge clk_i);
      #1;
      data_i = 16'h00FF;
      for (int k = 0; k < 34; k++) begin
         check_cycle();
         if (k == 15) check("b2b_first", rx, 16'h8001);
         if (k == 16) data_val_i = 1'b0;
      end
      check("b2b_second", rx, 16'h00FF);

      // Mid-word asynchronous reset
      @(negedge clk_i);
      drive(16'hFFFF, 4'd0, 1'b1);
      model_push(16'hFFFF, 4'd0);
      @(posedge clk_i);
      #1;
      data_val_i = 1'b0;
      repeat (7) check_cycle();
      #2;
      rst_n_i = 1'b0;
      #1;
      check("arst_bit", ser_data_o, 0);
      check("arst_val", ser_data_val_o, 0);
      check("arst_busy", busy_o, 0);
      exp_q.delete();
      @(posedge clk_i);
      @(negedge clk_i);
      check("arst_hold_val", ser_data_val_o, 0);
      rst_n_i = 1'b1;
      rx = '0;
      send_word(16'h1234, 4'd0);
      check("after_rst_word", rx, 16'h1234);

      // Randomized words against the model
      for (int i = 0; i < 40; i++) begin
         send_word(16'($urandom), 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
